// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the multiplier and its downstream
// dot-product accumulator.
package mult_pkg;

    localparam int MULT_OP_W  = 8;
    localparam int MULT_RES_W = 16;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_RUN  = 2'd1,
        ACC_HOLD = 2'd2
    } acc_state_t;

endpackage

// File: rtl/mult_dot_accum_if.sv
// Product-in / sum-out bundle for mult_dot_accum.
// The producer side (multiplier plus downstream consumer) uses the master modport.
interface mult_dot_accum_if
    import mult_pkg::*;
#(
    parameter int IN_W  = MULT_RES_W,
    parameter int ACC_W = 20
) ();

    logic             prod_valid;
    logic [IN_W-1:0]  prod;
    logic             clr;
    logic             sum_valid;
    logic [ACC_W-1:0] sum;
    logic             sum_ready;
    logic             busy;
    logic             ovf;

    modport master (
        output prod_valid, prod, clr, sum_ready,
        input  sum_valid, sum, busy, ovf
    );

    modport slave (
        input  prod_valid, prod, clr, sum_ready,
        output sum_valid, sum, busy, ovf
    );

endinterface

// File: rtl/mult_dot_accum_adder.sv
// Combinational accumulator adder: zero-extends the product and returns
// {carry, sum} so wrap detection lives in one place.
module mult_acc_adder #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W:0]   res
);

    assign res = {1'b0, a} + (ACC_W + 1)'(b);

endmodule

// File: rtl/mult_dot_accum.sv
// Sums N_TERMS consecutive valid products and presents the result on a
// valid/ready handshake, with a sticky wrap/drop error flag.
module mult_dot_accum
    import mult_pkg::*;
#(
    parameter int IN_W    = MULT_RES_W,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 20,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    mult_dot_accum_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    acc_state_t       state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] sum_reg;
    logic             sum_valid_reg;
    logic             busy_reg;
    logic             ovf_reg;

    logic [ACC_W:0]   add_next;
    logic [ACC_W-1:0] add_sum_next;
    logic             add_carry_next;

    // One adder serves both the running accumulate and the closing term.
    mult_acc_adder #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_adder (
        .a   (acc_reg),
        .b   (bus.prod),
        .res (add_next)
    );

    assign add_sum_next   = add_next[ACC_W-1:0];
    assign add_carry_next = add_next[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACC_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (bus.clr) begin
            // Abort: a coincident product is discarded silently, ovf untouched.
            state_reg     <= ACC_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sum_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ACC_IDLE: begin
                    if (bus.prod_valid) begin
                        acc_reg   <= ACC_W'(bus.prod);
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= ACC_RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                ACC_RUN: begin
                    if (bus.prod_valid) begin
                        ovf_reg <= ovf_reg | add_carry_next;
                        if (cnt_reg == LAST_CNT) begin
                            sum_reg       <= add_sum_next;
                            sum_valid_reg <= 1'b1;
                            acc_reg       <= '0;
                            cnt_reg       <= '0;
                            state_reg     <= ACC_HOLD;
                            busy_reg      <= 1'b0;
                        end else begin
                            acc_reg <= add_sum_next;
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ACC_HOLD: begin
                    if (bus.sum_ready) begin
                        sum_valid_reg <= 1'b0;
                        // Accepting a product on the handshake cycle avoids a bubble.
                        if (bus.prod_valid) begin
                            acc_reg   <= ACC_W'(bus.prod);
                            cnt_reg   <= CNT_W'(1);
                            state_reg <= ACC_RUN;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= ACC_IDLE;
                        end
                    end else if (bus.prod_valid) begin
                        ovf_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ACC_IDLE;
                    acc_reg       <= '0;
                    cnt_reg       <= '0;
                    sum_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.sum_valid = sum_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: doc/mult_dot_accum.md
Name: mult_dot_accum

Overview:
- Downstream consumer of the 8x8 shift-add multiplier's 16-bit product.
- Sums N_TERMS consecutive valid products into one wider dot-product result.
- Presents that result on a valid/ready output handshake to the next stage.
- Gives the multiplier's free-running result a framed, back-pressured interface for small vector dot products.

Parameters:
- IN_W, 16: product width; matches the multiplier result width.
- N_TERMS, 4: products per dot-product group; legal range 2..256.
- ACC_W, 20: accumulator/sum width; must be >= IN_W. Wrap is possible only if ACC_W < IN_W+clog2(N_TERMS).
- CNT_W, 8: term-counter width; must satisfy 2^CNT_W >= N_TERMS.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- prod_valid  input  1  prod holds a new product this cycle; single-cycle strobe per product.
- prod  input  IN_W  unsigned product from the multiplier.
- clr  input  1  synchronous abort of the current group.
- sum_valid  output  1  sum is valid; held until accepted.
- sum  output  ACC_W  completed dot-product sum.
- sum_ready  input  1  downstream accepts sum when high together with sum_valid.
- busy  output  1  high in ACC state, i.e. at least 1 term accepted, group not yet complete.
- ovf  output  1  sticky error flag: accumulator wrapped, or a product was dropped.

Behaviour:
- Interface: one clock domain; clk rising edge. rst is synchronous, active-high, and has highest priority.
- Reset values: sum_valid=0, sum=0, busy=0, ovf=0, internal acc=0, cnt=0, state=IDLE.
- States:
  - IDLE: acc=0, cnt=0. prod_valid -> acc<=prod, cnt<=1, go to ACC.
  - ACC: prod_valid -> acc<=acc+prod (modulo 2^ACC_W), cnt<=cnt+1. When the accepted term is the N_TERMS-th: sum<=acc+prod, sum_valid<=1, acc<=0, cnt<=0, go to HOLD.
  - HOLD: sum and sum_valid stable until sum_ready=1.
    - sum_ready=1 and prod_valid=0: sum_valid<=0, go to IDLE.
    - sum_ready=1 and prod_valid=1 in the same cycle: handshake completes and the product is accepted as term 1 of the next group (acc<=prod, cnt<=1, go to ACC). No bubble.
    - prod_valid=1 with sum_ready=0: product dropped, ovf<=1, state unchanged.
- Latency: sum_valid rises on the clock edge after the cycle in which the N_TERMS-th product is presented. Throughput is one product per cycle.
- Arithmetic: unsigned only; prod is zero-extended to ACC_W.
  - Carry out of bit ACC_W-1 on any add sets ovf<=1; the sum keeps the wrapped value.
  - ovf clears only on rst.
- busy: 1 in ACC state, 0 in IDLE and HOLD.
- clr (priority below rst, above all else):
  - Any state -> IDLE; acc=0, cnt=0, sum_valid<=0.
  - A prod_valid in the same cycle is discarded and does not set ovf.
  - A pending HOLD sum is lost; sum keeps its stale value, which is don't-care while sum_valid=0.
- rst mid-group or mid-HOLD: identical to the reset values above; no partial sum is emitted.
- N_TERMS boundary: cnt compares against N_TERMS-1 before increment, so cnt never exceeds N_TERMS-1.
- Unknown states are recovered to IDLE.

Decomposition:
- Shared package mult_pkg:
  - Constants MULT_OP_W=8 and MULT_RES_W=16. IN_W default references MULT_RES_W.
  - State encoding constants ACC_IDLE=2'd0, ACC_RUN=2'd1, ACC_HOLD=2'd2. The RTL state is named ACC_RUN and is reported externally as busy.
- One sub-module is natural: mult_acc_adder, a combinational IN_W+ACC_W adder returning {carry, sum}. It is shared by the accumulate path and the final-term path so the carry and ovf logic exist once.
- The FSM, counter and output register stay in mult_dot_accum.

Test Plan:
- Basic group: N_TERMS=4, sum_ready=1; products 100, 200, 300, 65535 on consecutive cycles -> sum_valid for 1 cycle, one clock after the 4th product; sum=66135; ovf=0; busy high for 3 cycles.
- Back-pressure: same products, sum_ready=0 for 5 cycles, then 1 -> sum holds 66135 with sum_valid=1 throughout; products 7 and 9 presented during the hold are dropped, ovf=1. The next group starts clean from IDLE.
- Zero-bubble: sum_ready=1 and prod_valid=1 (prod=5) in the same HOLD cycle, then 6, 7, 8 -> first sum accepted; second sum=26.
- Wrap: ACC_W=17, N_TERMS=4, four products of 0xFFFF -> sum=131068 (262140 mod 2^17), ovf=1.
- clr mid-group: products 10, 20, then clr together with prod=30 -> no sum_valid, ovf=0. Then 1, 2, 3, 4 -> sum=10.
- Reset mid-HOLD: rst while sum_valid=1 -> next cycle sum_valid=0, sum=0, busy=0, ovf=0. A new group of four 1s -> sum=4.
